// File: rtl/hpm_counter_bank_pkg.sv
// Shared constants for the HPM counter bank: mhpmevent field layout, privilege
// encodings and the base CSR addresses of the mhpmcounter/mhpmevent ranges.
package hpm_counter_bank_pkg;

   // mhpmevent field positions
   localparam int unsigned HPM_OF_BIT   = 63;
   localparam int unsigned HPM_MINH_BIT = 62;
   localparam int unsigned HPM_SINH_BIT = 61;
   localparam int unsigned HPM_UINH_BIT = 60;
   localparam int unsigned HPM_SEL_MSB  = 55;

   // mhpmevent bits [59:56] are forced to zero on write
   localparam logic [63:0] HPM_EVENT_WARL_MASK = 64'h0F00_0000_0000_0000;

   // Privilege levels
   localparam logic [1:0] PRIV_LVL_U = 2'b00;
   localparam logic [1:0] PRIV_LVL_S = 2'b01;
   localparam logic [1:0] PRIV_LVL_M = 2'b11;

   // First entry of each CSR range; counter k lives at base + (k - 3)
   localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;
   localparam logic [11:0] CSR_MHPM_EVENT_3   = 12'h323;

   // True when the event register inhibits counting at the given privilege
   function automatic logic hpm_priv_inhibited(input logic [63:0] evt, input logic [1:0] priv);
      logic inh;
      inh = 1'b0;
      unique case (priv)
         PRIV_LVL_M: inh = evt[HPM_MINH_BIT];
         PRIV_LVL_S: inh = evt[HPM_SINH_BIT];
         PRIV_LVL_U: inh = evt[HPM_UINH_BIT];
         default:    inh = 1'b0;
      endcase
      return inh;
   endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One programmable event counter: event register, registered increment
// (stage 0), counter accumulate with overflow detect (stage 1).
module hpm_counter_slice
   import hpm_counter_bank_pkg::*;
#(
   parameter int unsigned XLEN            = 64,
   parameter int unsigned CNT_WIDTH       = 64,
   parameter int unsigned HPM_NUM_EVENTS  = 28,
   parameter int unsigned EVENT_INC_WIDTH = 3
) (
   input  logic                                      clk_i,
   input  logic                                      rstn_i,
   input  logic                                      cnt_we_i,
   input  logic                                      evt_we_i,
   input  logic [XLEN-1:0]                           data_i,
   input  logic                                      inhibit_i,
   input  logic [1:0]                                priv_lvl_i,
   input  logic [HPM_NUM_EVENTS*EVENT_INC_WIDTH-1:0] events_i,
   output logic [CNT_WIDTH-1:0]                      cnt_o,
   output logic [XLEN-1:0]                           evt_o,
   output logic                                      ovf_set_o
);

   localparam int unsigned SelW = HPM_SEL_MSB + 1;

   logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]            evt_q, evt_d;
   logic [EVENT_INC_WIDTH-1:0] inc_q, inc_d, inc_sel;
   logic [SelW-1:0]            sel;
   logic                       sel_hit;
   logic [CNT_WIDTH:0]         sum;
   logic                       of_set;

   assign sel = evt_q[HPM_SEL_MSB:0];

   // Stage 0: select the event's increment and gate it with the inhibits
   always_comb begin
      inc_sel = '0;
      sel_hit = 1'b0;
      for (int unsigned e = 1; e <= HPM_NUM_EVENTS; e++) begin
         if (sel == SelW'(e)) begin
            inc_sel = events_i[(e-1)*EVENT_INC_WIDTH +: EVENT_INC_WIDTH];
            sel_hit = 1'b1;
         end
      end
      inc_d = '0;
      // A counter write drops the event sampled in the same cycle
      if (sel_hit && !inhibit_i && !hpm_priv_inhibited(evt_q, priv_lvl_i) && !cnt_we_i) begin
         inc_d = inc_sel;
      end
   end

   // Stage 1: accumulate, detect carry-out, apply CSR writes with priority
   always_comb begin
      sum    = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc_q);
      of_set = sum[CNT_WIDTH] & ~evt_q[HPM_OF_BIT] & ~cnt_we_i;
      cnt_d  = cnt_we_i ? data_i[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
      evt_d  = evt_q;
      if (evt_we_i) begin
         evt_d = data_i & ~HPM_EVENT_WARL_MASK;
      end else if (of_set) begin
         evt_d[HPM_OF_BIT] = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
         evt_q <= '0;
         inc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         evt_q <= evt_d;
         inc_q <= inc_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign evt_o     = evt_q;
   // A same-cycle event write owns OF, so it also suppresses the pulse
   assign ovf_set_o = of_set & ~evt_we_i;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of programmable HPM counters (mhpmcounter3.. / mhpmevent3..) with CSR
// decode, read mux and a registered overflow interrupt pulse.
module hpm_counter_bank
   import hpm_counter_bank_pkg::*;
#(
   parameter int unsigned CSR_ADDR_WIDTH   = 12,
   parameter int unsigned XLEN             = 64,
   parameter int unsigned CNT_WIDTH        = 64,
   parameter int unsigned HPM_NUM_EVENTS   = 28,
   parameter int unsigned HPM_NUM_COUNTERS = 29,
   parameter int unsigned EVENT_INC_WIDTH  = 3
) (
   input  logic                                      clk_i,
   input  logic                                      rstn_i,
   input  logic [CSR_ADDR_WIDTH-1:0]                 addr_i,
   input  logic                                      we_i,
   input  logic [XLEN-1:0]                           data_i,
   output logic [XLEN-1:0]                           data_o,
   input  logic [31:0]                               mcountinhibit_i,
   input  logic [1:0]                                priv_lvl_i,
   input  logic [HPM_NUM_EVENTS*EVENT_INC_WIDTH-1:0] events_i,
   output logic                                      count_ovf_int_req_o,
   output logic [HPM_NUM_COUNTERS+2:3]               mhpm_ovf_bits_o
);

   if (XLEN != 64) begin : gen_xlen_check
      $error("hpm_counter_bank: only XLEN = 64 is supported");
   end
   if (CNT_WIDTH < 32 || CNT_WIDTH > 64) begin : gen_cnt_width_check
      $error("hpm_counter_bank: CNT_WIDTH must be 32..64");
   end
   if (HPM_NUM_COUNTERS < 1 || HPM_NUM_COUNTERS > 29) begin : gen_num_cnt_check
      $error("hpm_counter_bank: HPM_NUM_COUNTERS must be 1..29");
   end

   logic [CNT_WIDTH-1:0]        cnt [HPM_NUM_COUNTERS];
   logic [XLEN-1:0]             evt [HPM_NUM_COUNTERS];
   logic [HPM_NUM_COUNTERS-1:0] cnt_we, evt_we, ovf_set;
   logic                        irq_q;
   logic                        unused_inhibit;

   // Only bits 3..HPM_NUM_COUNTERS+2 of mcountinhibit are meaningful here
   assign unused_inhibit = ^mcountinhibit_i;

   // CSR decode and read mux; reads see registered state, so a read during a
   // write returns the old value
   always_comb begin
      cnt_we = '0;
      evt_we = '0;
      data_o = '0;
      for (int unsigned k = 0; k < HPM_NUM_COUNTERS; k++) begin
         if (addr_i == CSR_ADDR_WIDTH'(CSR_MHPM_COUNTER_3 + 12'(k))) begin
            cnt_we[k] = we_i;
            data_o    = XLEN'(cnt[k]);
         end
         if (addr_i == CSR_ADDR_WIDTH'(CSR_MHPM_EVENT_3 + 12'(k))) begin
            evt_we[k] = we_i;
            data_o    = evt[k];
         end
      end
   end

   for (genvar k = 0; k < HPM_NUM_COUNTERS; k++) begin : gen_slice
      hpm_counter_slice #(
         .XLEN            (XLEN),
         .CNT_WIDTH       (CNT_WIDTH),
         .HPM_NUM_EVENTS  (HPM_NUM_EVENTS),
         .EVENT_INC_WIDTH (EVENT_INC_WIDTH)
      ) u_slice (
         .clk_i      (clk_i),
         .rstn_i     (rstn_i),
         .cnt_we_i   (cnt_we[k]),
         .evt_we_i   (evt_we[k]),
         .data_i     (data_i),
         .inhibit_i  (mcountinhibit_i[k+3]),
         .priv_lvl_i (priv_lvl_i),
         .events_i   (events_i),
         .cnt_o      (cnt[k]),
         .evt_o      (evt[k]),
         .ovf_set_o  (ovf_set[k])
      );
      assign mhpm_ovf_bits_o[k+3] = evt[k][HPM_OF_BIT];
   end

   // One shared pulse, however many counters overflow together
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |ovf_set;
      end
   end

   assign count_ovf_int_req_o = irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed self-checking bench for hpm_counter_bank (4 counters, 40-bit).
module tb_hpm_counter_bank;
   import hpm_counter_bank_pkg::*;

   localparam int unsigned NCNT = 4;
   localparam int unsigned NEV  = 28;
   localparam int unsigned IW   = 3;
   localparam int unsigned CW   = 40;
   localparam logic [63:0] CMAX = 64'h0000_00FF_FFFF_FFFF;

   logic                 clk_i = 1'b0;
   logic                 rstn_i;
   logic [11:0]          addr_i;
   logic                 we_i;
   logic [63:0]          data_i;
   logic [63:0]          data_o;
   logic [31:0]          mcountinhibit_i;
   logic [1:0]           priv_lvl_i;
   logic [NEV*IW-1:0]    events_i;
   logic                 count_ovf_int_req_o;
   logic [NCNT+2:3]      mhpm_ovf_bits_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   hpm_counter_bank #(
      .CSR_ADDR_WIDTH   (12),
      .XLEN             (64),
      .CNT_WIDTH        (CW),
      .HPM_NUM_EVENTS   (NEV),
      .HPM_NUM_COUNTERS (NCNT),
      .EVENT_INC_WIDTH  (IW)
   ) dut (
      .clk_i               (clk_i),
      .rstn_i              (rstn_i),
      .addr_i              (addr_i),
      .we_i                (we_i),
      .data_i              (data_i),
      .data_o              (data_o),
      .mcountinhibit_i     (mcountinhibit_i),
      .priv_lvl_i          (priv_lvl_i),
      .events_i            (events_i),
      .count_ovf_int_req_o (count_ovf_int_req_o),
      .mhpm_ovf_bits_o     (mhpm_ovf_bits_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [11:0] waddr;
      logic [63:0] wdata;
      logic [11:0] raddr;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic rd_check(input string name, input logic [11:0] addr, input logic [63:0] exp);
      addr_i = addr;
      #1;
      check(name, data_o, exp);
   endtask

   task automatic csr_wr(input logic [11:0] addr, input logic [63:0] data);
      we_i   = 1'b1;
      addr_i = addr;
      data_i = data;
      tick();
      we_i   = 1'b0;
   endtask

   task automatic set_ev(input int unsigned e, input logic [IW-1:0] v);
      events_i[(e-1)*IW +: IW] = v;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      events_i = '0;
      mcountinhibit_i = '0;
      we_i = 1'b0;
      tick();
      tick();
      rstn_i = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{12'hB03, 64'h0000_0012_3456_789A, 12'hB03, 64'h0000_0012_3456_789A};
      vecs[1]  = '{12'hB04, 64'hFFFF_FFFF_FFFF_FFFF, 12'hB04, 64'h0000_00FF_FFFF_FFFF};
      vecs[2]  = '{12'h323, 64'hFFFF_FFFF_FFFF_FFFF, 12'h323, 64'hF0FF_FFFF_FFFF_FFFF};
      vecs[3]  = '{12'hB0A, 64'h0000_0000_0000_0055, 12'hB0A, 64'h0};
      vecs[4]  = '{12'hB0A, 64'h0000_0000_0000_0077, 12'hB03, 64'h0000_0012_3456_789A};
      vecs[5]  = '{12'h32A, 64'hFFFF_FFFF_FFFF_FFFF, 12'h32A, 64'h0};
      vecs[6]  = '{12'h32A, 64'h0,                   12'h323, 64'hF0FF_FFFF_FFFF_FFFF};
      vecs[7]  = '{12'hB07, 64'h0000_0000_0000_0099, 12'hB07, 64'h0};
      vecs[8]  = '{12'h300, 64'h0000_0000_0000_1234, 12'h300, 64'h0};
      vecs[9]  = '{12'hB06, 64'h0000_0000_0000_0005, 12'hB06, 64'h5};
      vecs[10] = '{12'h326, 64'h0000_0000_0000_0007, 12'h326, 64'h7};
      vecs[11] = '{12'hB04, 64'h0000_0001_0000_0000, 12'hB04, 64'h0000_0001_0000_0000};

      rstn_i = 1'b0;
      addr_i = 12'hB03;
      we_i = 1'b0;
      data_i = '0;
      mcountinhibit_i = '0;
      priv_lvl_i = PRIV_LVL_M;
      events_i = '0;
      tick();
      tick();
      rd_check("reset_cnt3", 12'hB03, 64'h0);
      rd_check("reset_evt3", 12'h323, 64'h0);
      check("reset_irq", {63'b0, count_ovf_int_req_o}, 64'h0);
      check("reset_ovf_bits", {60'b0, mhpm_ovf_bits_o}, 64'h0);
      rstn_i = 1'b1;
      tick();

      // Table: CSR write/read, WARL and unimplemented indices (events idle)
      for (int i = 0; i < 12; i++) begin
         csr_wr(vecs[i].waddr, vecs[i].wdata);
         rd_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      end
      check("written_of_bits", {60'b0, mhpm_ovf_bits_o}, 64'h1);
      check("written_of_no_irq", {63'b0, count_ovf_int_req_o}, 64'h0);

      // Two-cycle latency, then asynchronous reset mid-count
      do_reset();
      csr_wr(12'h323, 64'h1);
      set_ev(1, 3);
      tick();
      set_ev(1, 0);
      rd_check("lat_t1", 12'hB03, 64'h0);
      tick();
      rd_check("lat_t2", 12'hB03, 64'h3);
      set_ev(1, 3);
      repeat (3) tick();
      rstn_i = 1'b0;
      rd_check("midrst_cnt3", 12'hB03, 64'h0);
      rd_check("midrst_evt3", 12'h323, 64'h0);
      check("midrst_irq", {63'b0, count_ovf_int_req_o}, 64'h0);
      tick();
      rstn_i = 1'b1;
      csr_wr(12'h323, 64'h1);
      tick();
      set_ev(1, 0);
      rd_check("postrst_t1", 12'hB03, 64'h0);
      tick();
      rd_check("postrst_t2", 12'hB03, 64'h3);

      // Multi-bit increments and invalid selects
      do_reset();
      csr_wr(12'h325, 64'h2);
      set_ev(2, 7);
      repeat (4) tick();
      set_ev(2, 0);
      repeat (2) tick();
      rd_check("multi_inc", 12'hB05, 64'd28);
      csr_wr(12'h325, 64'h0);
      set_ev(2, 7);
      repeat (3) tick();
      set_ev(2, 0);
      repeat (2) tick();
      rd_check("sel_zero", 12'hB05, 64'd28);
      csr_wr(12'h325, 64'd29);
      set_ev(2, 7);
      repeat (3) tick();
      set_ev(2, 0);
      repeat (2) tick();
      rd_check("sel_over", 12'hB05, 64'd28);

      // Privilege and mcountinhibit
      csr_wr(12'h325, (64'h1 << HPM_MINH_BIT) | 64'h2);
      set_ev(2, 7);
      repeat (2) tick();
      set_ev(2, 0);
      repeat (2) tick();
      rd_check("minh_m", 12'hB05, 64'd28);
      priv_lvl_i = PRIV_LVL_U;
      set_ev(2, 7);
      repeat (2) tick();
      set_ev(2, 0);
      repeat (2) tick();
      rd_check("minh_u", 12'hB05, 64'd42);
      csr_wr(12'h323, 64'h1);
      mcountinhibit_i = 32'h20;
      set_ev(1, 1);
      set_ev(2, 7);
      repeat (3) tick();
      set_ev(1, 0);
      set_ev(2, 0);
      repeat (2) tick();
      rd_check("mci_other", 12'hB03, 64'd3);
      rd_check("mci_frozen", 12'hB05, 64'd42);
      mcountinhibit_i = '0;

      // Overflow
      do_reset();
      priv_lvl_i = PRIV_LVL_M;
      csr_wr(12'h325, 64'h2);
      csr_wr(12'hB05, CMAX - 64'd1);
      set_ev(2, 5);
      tick();
      set_ev(2, 0);
      check("ovf_irq_early", {63'b0, count_ovf_int_req_o}, 64'h0);
      tick();
      check("ovf_irq", {63'b0, count_ovf_int_req_o}, 64'h1);
      check("ovf_bits", {60'b0, mhpm_ovf_bits_o}, 64'h4);
      rd_check("ovf_cnt", 12'hB05, 64'd3);
      rd_check("ovf_evt", 12'h325, 64'h8000_0000_0000_0002);
      tick();
      check("ovf_irq_one", {63'b0, count_ovf_int_req_o}, 64'h0);
      csr_wr(12'hB05, CMAX);
      set_ev(2, 1);
      tick();
      set_ev(2, 0);
      tick();
      check("rewrap_irq", {63'b0, count_ovf_int_req_o}, 64'h0);
      rd_check("rewrap_cnt", 12'hB05, 64'h0);
      rd_check("rewrap_evt", 12'h325, 64'h8000_0000_0000_0002);
      tick();
      check("rewrap_irq2", {63'b0, count_ovf_int_req_o}, 64'h0);

      // Simultaneous overflow on counters 3 and 4
      csr_wr(12'h323, 64'h1);
      csr_wr(12'h324, 64'h1);
      csr_wr(12'hB03, CMAX);
      csr_wr(12'hB04, CMAX);
      set_ev(1, 1);
      tick();
      set_ev(1, 0);
      tick();
      check("multi_ovf_irq", {63'b0, count_ovf_int_req_o}, 64'h1);
      check("multi_ovf_bits", {60'b0, mhpm_ovf_bits_o}, 64'h7);
      tick();
      check("multi_ovf_irq_one", {63'b0, count_ovf_int_req_o}, 64'h0);

      // Counter write collides with a pending increment
      do_reset();
      csr_wr(12'h325, 64'h2);
      set_ev(2, 4);
      tick();
      we_i = 1'b1;
      addr_i = 12'hB05;
      data_i = 64'd100;
      #1;
      check("rd_during_wr", data_o, 64'h0);
      tick();
      we_i = 1'b0;
      set_ev(2, 0);
      rd_check("wr_collide", 12'hB05, 64'd100);
      repeat (2) tick();
      rd_check("wr_collide_late", 12'hB05, 64'd100);

      // Event write with OF=0 in the overflow cycle
      csr_wr(12'hB05, CMAX);
      set_ev(2, 1);
      tick();
      set_ev(2, 0);
      we_i = 1'b1;
      addr_i = 12'h325;
      data_i = 64'h2;
      tick();
      we_i = 1'b0;
      check("evtwr_irq", {63'b0, count_ovf_int_req_o}, 64'h0);
      check("evtwr_bits", {60'b0, mhpm_ovf_bits_o}, 64'h0);
      rd_check("evtwr_evt", 12'h325, 64'h2);
      rd_check("evtwr_cnt", 12'hB05, 64'h0);
      tick();
      check("evtwr_irq2", {63'b0, count_ovf_int_req_o}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
